// File: rtl/gcd_controller.sv
// Control FSM for a subtract-and-swap GCD datapath: loads A and B from data_in,
// then steers one subtraction per clock until A == B or the iteration limit is hit.
module gcd_controller #(
    parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        gt,
    input  logic        lt,
    input  logic        eq,
    output logic        ldA,
    output logic        ldB,
    output logic        sel1,
    output logic        sel2,
    output logic        sel_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t next_state;

    logic at_limit;
    logic can_start;
    logic do_sub;

    assign at_limit  = (iter_count == MAX_ITER);
    assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
    // A subtraction happens only when the operands differ, a direction is known
    // and the budget is not exhausted; this also guards iter_count against wrap.
    assign do_sub    = (state == CALC) && !eq && !at_limit && (gt || lt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_count <= '0;
        end else if (abort) begin
            iter_count <= iter_count;
        end else if (can_start && start) begin
            iter_count <= '0;
        end else if (do_sub) begin
            iter_count <= iter_count + 16'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start) next_state = LOAD_A;
            LOAD_A:          if (in_valid) next_state = LOAD_B;
            LOAD_B:          if (in_valid) next_state = CALC;
            CALC: begin
                if (eq) begin
                    next_state = DONE;
                end else if (at_limit) begin
                    next_state = ERR;
                end
            end
            default:         next_state = IDLE;
        endcase
    end

    always_comb begin
        ldA      = 1'b0;
        ldB      = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        sel_in   = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                sel_in   = 1'b1;
                ldA      = in_valid;
                busy     = 1'b1;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                sel_in   = 1'b1;
                ldB      = in_valid;
                busy     = 1'b1;
            end
            CALC: begin
                busy = 1'b1;
                if (!eq && !at_limit) begin
                    if (gt) begin
                        ldA  = 1'b1;
                        sel1 = 1'b1;
                    end else if (lt) begin
                        ldB  = 1'b1;
                        sel2 = 1'b1;
                    end
                end
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: wraps the controller around a behavioural A/B datapath
// and checks results against a plain-arithmetic subtraction-GCD reference.
module tb_gcd_controller;

    localparam int MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic        gt;
    logic        lt;
    logic        eq;
    logic        ldA;
    logic        ldB;
    logic        sel1;
    logic        sel2;
    logic        sel_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] iter_count;
    logic [7:0]  data_in;

    logic [7:0]  dp_a;
    logic [7:0]  dp_b;
    logic [7:0]  sub_out;
    logic [7:0]  load_bus;
    logic [15:0] trace[$];

    int n_checks = 0;
    int n_pass   = 0;

    gcd_controller #(.MAX_ITER(16'(MAX))) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .gt(gt), .lt(lt), .eq(eq),
        .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .busy(busy), .done(done), .err(err), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Behavioural datapath the controller steers.
    assign sub_out  = (sel1 ? dp_a : dp_b) - (sel2 ? dp_a : dp_b);
    assign load_bus = sel_in ? data_in : sub_out;
    assign gt = dp_a > dp_b;
    assign lt = dp_a < dp_b;
    assign eq = dp_a == dp_b;

    always_ff @(posedge clk) begin
        if (ldA) dp_a <= load_bus;
        if (ldB) dp_b <= load_bus;
    end

    task automatic model_gcd(input int a, input int b, output int res, output int n, output bit e);
        n = 0;
        while (a != b && n < MAX) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        e   = (a != b);
        res = a;
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output int n_lda, output int n_ldb);
        bit loaded;
        trace.delete();
        lat = 0; n_lda = 0; n_ldb = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; data_in = av;
        @(posedge clk); #1 data_in = bv;
        @(posedge clk); #1 in_valid = 1'b0; #1;
        while (!(done || err) && lat < 100) begin
            loaded = ldA || ldB;
            n_lda += int'(ldA);
            n_ldb += int'(ldB);
            @(posedge clk); lat++; #2;
            if (loaded) trace.push_back({dp_a, dp_b});
        end
        n_checks++;
        if (!(done || err)) $display("[TB] FAIL op_finish a=%0d b=%0d: done|err=0 after %0d cycles, required 1", av, bv, lat);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; #3;
        n_checks++;
        if ({ldA, ldB, sel1, sel2, sel_in, in_ready, busy, done, err, iter_count} !== 25'b0)
            $display("[TB] FAIL reset_outputs: got %b iter=%0d, required all 0", {ldA, ldB, sel1, sel2, sel_in, in_ready, busy, done, err}, iter_count);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, na, nb;
        logic [15:0] exp_trace[4];
        exp_trace[0] = {8'd30, 8'd18};
        exp_trace[1] = {8'd12, 8'd18};
        exp_trace[2] = {8'd12, 8'd6};
        exp_trace[3] = {8'd6, 8'd6};
        do_op(8'd48, 8'd18, lat, na, nb);
        n_checks++;
        if (done !== 1'b1 || dp_a !== 8'd6 || iter_count !== 16'd4)
            $display("[TB] FAIL basic_48_18: done=%b A=%0d iter=%0d, required done=1 A=6 iter=4", done, dp_a, iter_count);
        else n_pass++;
        n_checks++;
        if (lat != 5) $display("[TB] FAIL basic_latency: got %0d, required 5", lat);
        else n_pass++;
        n_checks++;
        if (trace.size() != 4) $display("[TB] FAIL basic_trace_len: got %0d, required 4", trace.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < trace.size(); i++) begin
            n_checks++;
            if (trace[i] !== exp_trace[i])
                $display("[TB] FAIL basic_trace_%0d: got %0d/%0d, required %0d/%0d", i, trace[i][15:8], trace[i][7:0], exp_trace[i][15:8], exp_trace[i][7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_equal();
        int lat, na, nb;
        do_op(8'd7, 8'd7, lat, na, nb);
        n_checks++;
        if (done !== 1'b1 || lat != 1 || iter_count !== 16'd0 || na != 0 || nb != 0)
            $display("[TB] FAIL equal_7_7: done=%b lat=%0d iter=%0d ldA=%0d ldB=%0d, required 1/1/0/0/0", done, lat, iter_count, na, nb);
        else n_pass++;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL done_hold: done=%b busy=%b, required 1/0", done, busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, na, nb;
        do_op(8'd0, 8'd5, lat, na, nb);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0 || nb != MAX || na != 0 || iter_count !== 16'(MAX))
            $display("[TB] FAIL timeout_0_5: err=%b done=%b ldB=%0d ldA=%0d iter=%0d, required 1/0/%0d/0/%0d", err, done, nb, na, iter_count, MAX, MAX);
        else n_pass++;
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (err !== 1'b1 || iter_count !== 16'(MAX)) $display("[TB] FAIL timeout_hold: err=%b iter=%0d, required 1/%0d", err, iter_count, MAX);
        else n_pass++;
    endtask

    task automatic test_stall();
        int k;
        bit ok;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (in_ready !== 1'b1 || ldA !== 1'b0 || sel_in !== 1'b1) ok = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!ok) $display("[TB] FAIL stall_load_a: in_ready=%b ldA=%b sel_in=%b, required 1/0/1", in_ready, ldA, sel_in);
        else n_pass++;
        in_valid = 1'b1; data_in = 8'd9; #1;
        n_checks++;
        if (ldA !== 1'b1) $display("[TB] FAIL stall_lda_rise: got %b, required 1", ldA);
        else n_pass++;
        @(posedge clk); #1 data_in = 8'd6;
        @(posedge clk); #1 in_valid = 1'b0;
        k = 0;
        while (!done && !err && k < 50) begin
            @(posedge clk); #2; k++;
        end
        n_checks++;
        if (done !== 1'b1 || dp_a !== 8'd3 || iter_count !== 16'd2)
            $display("[TB] FAIL stall_result: done=%b A=%0d iter=%0d, required 1/3/2", done, dp_a, iter_count);
        else n_pass++;
    endtask

    task automatic test_start_abort();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; data_in = 8'd40;
        @(posedge clk); #1 data_in = 8'd3;
        @(posedge clk); #1 in_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b1 || iter_count !== 16'd1 || in_ready !== 1'b0)
            $display("[TB] FAIL start_in_calc: busy=%b iter=%0d in_ready=%b, required 1/1/0", busy, iter_count, in_ready);
        else n_pass++;
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || iter_count !== 16'd1)
            $display("[TB] FAIL abort_calc: busy=%b done=%b err=%b iter=%0d, required 0/0/0/1", busy, done, err, iter_count);
        else n_pass++;
        #1 abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0 || iter_count !== 16'd1)
            $display("[TB] FAIL abort_over_start: busy=%b iter=%0d, required 0/1", busy, iter_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; data_in = 8'd40;
        @(posedge clk); #1 data_in = 8'd3;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3 rst = 1'b1; #1;
        n_checks++;
        if ({ldA, ldB, sel1, sel2, sel_in, in_ready, busy, done, err, iter_count} !== 25'b0)
            $display("[TB] FAIL reset_mid: got %b iter=%0d, required all 0", {ldA, ldB, sel1, sel2, sel_in, in_ready, busy, done, err}, iter_count);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL reset_release_idle: busy=%b in_ready=%b done=%b, required 0/0/0", busy, in_ready, done);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, na, nb, res, n;
        bit e;
        logic [7:0] av, bv;
        for (int t = 0; t < 12; t++) begin
            av = 8'($urandom_range(1, 60));
            bv = 8'($urandom_range(1, 60));
            model_gcd(int'(av), int'(bv), res, n, e);
            do_op(av, bv, lat, na, nb);
            n_checks++;
            if (err !== e || done !== !e || iter_count !== 16'(n))
                $display("[TB] FAIL rand_status a=%0d b=%0d: err=%b done=%b iter=%0d, required %b/%b/%0d", av, bv, err, done, iter_count, e, !e, n);
            else n_pass++;
            n_checks++;
            if (lat != n + 1 || na + nb != n)
                $display("[TB] FAIL rand_timing a=%0d b=%0d: lat=%0d loads=%0d, required %0d/%0d", av, bv, lat, na + nb, n + 1, n);
            else n_pass++;
            if (!e) begin
                n_checks++;
                if (dp_a !== 8'(res)) $display("[TB] FAIL rand_result a=%0d b=%0d: got %0d, required %0d", av, bv, dp_a, res);
                else n_pass++;
            end
        end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; data_in = 8'd0;
        dp_a = 8'd0; dp_b = 8'd0;
        test_reset();
        test_basic();
        test_equal();
        test_timeout();
        test_stall();
        test_start_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 16'hFFFF, giving the maximum number of subtraction iterations before timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new GCD operation.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of any operation.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operand present on the datapath data_in bus.
REQ-007 The block SHALL have port in_ready, output, 1 bit: controller accepting an operand this cycle.
REQ-008 The block SHALL have ports gt, lt and eq, inputs, 1 bit each: datapath compare status of A versus B.
REQ-009 The block SHALL have ports ldA and ldB, outputs, 1 bit each: register A and register B load enables.
REQ-010 The block SHALL have port sel1, output, 1 bit: subtractor minuend select; 1 = A, 0 = B.
REQ-011 The block SHALL have port sel2, output, 1 bit: subtractor subtrahend select; 1 = A, 0 = B.
REQ-012 The block SHALL have port sel_in, output, 1 bit: load-bus select; 1 = data_in, 0 = subtractor output.
REQ-013 The block SHALL have ports busy, done and err, outputs, 1 bit each: operation in progress, result valid in register A, timeout.
REQ-014 The block SHALL have port iter_count, output, 16 bits: number of subtraction iterations in the current or last operation.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD_A, LOAD_B, CALC, DONE and ERR, in a single FSM.
REQ-016 Default outputs SHALL be ldA=ldB=sel1=sel2=sel_in=in_ready=0 unless a requirement below sets them.
REQ-017 In IDLE, DONE or ERR, start=1 SHALL move the FSM to LOAD_A and clear iter_count to 0 at the same edge.
REQ-018 In LOAD_A, the outputs SHALL be in_ready=1 and sel_in=1, and ldA SHALL equal in_valid.
REQ-019 In LOAD_A, in_valid=1 SHALL move the FSM to LOAD_B; otherwise the FSM SHALL stay in LOAD_A indefinitely.
REQ-020 In LOAD_B, the outputs SHALL be in_ready=1 and sel_in=1, and ldB SHALL equal in_valid.
REQ-021 In LOAD_B, in_valid=1 SHALL move the FSM to CALC.
REQ-022 CALC outputs are combinational from state and status, and status SHALL be evaluated with priority eq > gt > lt.
REQ-023 CALC with eq=1 SHALL issue no load and move the FSM to DONE.
REQ-024 CALC with gt=1 and iter_count < MAX_ITER SHALL drive ldA=1, sel1=1, sel2=0, sel_in=0 (A <= A-B) and increment iter_count.
REQ-025 CALC with lt=1 and iter_count < MAX_ITER SHALL drive ldB=1, sel1=0, sel2=1, sel_in=0 (B <= B-A) and increment iter_count.
REQ-026 CALC with eq=0 and iter_count == MAX_ITER SHALL issue no load and move the FSM to ERR.
REQ-027 CALC with none of gt, lt or eq asserted SHALL issue no load and stay in CALC, without incrementing iter_count.
REQ-028 The block SHALL perform one subtraction per clock, and status SHALL be sampled the cycle after each load.
REQ-029 busy SHALL be 1 in LOAD_A, LOAD_B and CALC, and 0 otherwise.
REQ-030 done SHALL be 1 throughout DONE, and err SHALL be 1 throughout ERR; both SHALL hold until the next start or abort.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 abort=1 SHALL force the FSM to IDLE at the next edge from any state; iter_count SHALL hold its value.
REQ-033 abort SHALL win over a simultaneous start.
REQ-034 iter_count SHALL never exceed MAX_ITER and SHALL never wrap.
REQ-035 Latency from the LOAD_B handshake edge to done=1 SHALL be N+1 cycles, where N is the final iter_count.

Reset
REQ-036 On rst=1, at any time and regardless of clk, the FSM SHALL enter IDLE, iter_count SHALL become 0, and all outputs SHALL become 0.
REQ-037 Reset asserted mid-operation SHALL discard the operation, and the FSM SHALL require a new start after release.

Verification
REQ-038 The bench SHALL cover: start, load A=48, B=18 -> loads of 30/18, 12/18, 12/6, 6/6; done=1 with A=6 and iter_count=4.
REQ-039 The bench SHALL cover: load A=7, B=7 -> CALC sees eq; done=1 one cycle after the LOAD_B edge; iter_count=0; no ldA or ldB pulses.
REQ-040 The bench SHALL cover: MAX_ITER=8, load A=0, B=5 -> 8 ldB pulses, then err=1, iter_count=8, done=0.
REQ-041 The bench SHALL cover: in_valid held low 5 cycles in LOAD_A -> in_ready=1, ldA=0 throughout; ldA pulses on the cycle in_valid rises.
REQ-042 The bench SHALL cover: start pulsed during CALC -> ignored; abort during CALC -> IDLE next edge, busy=0, iter_count holds.
REQ-043 The bench SHALL cover: rst asserted between clock edges during CALC -> all outputs 0 immediately; IDLE after release.
